// File: rtl/ticker_prog.sv
// ---------------------------------------------------------------------------
// ticker_prog -- programmable periodic / one-shot tick generator
//
// A WIDTH-bit counter runs while the FSM is in RUN and emits a one-cycle
// tick every period_r+1 enabled cycles. In periodic mode (mode = 0) the
// block keeps running. In one-shot mode (mode = 1) it returns to IDLE after
// one tick. A new period is staged in a shadow register and takes effect
// only at an interval boundary (the tick cycle) or while idle, so a running
// interval is never cut short or stretched.
//
// Optional feature (macro TICKER_PROG_TICK_CNT_EN): adds a CNT_WIDTH-bit
// free-running tick counter output tick_cnt.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   run gate; low freezes counter, state and tick_cnt
//   mode         in   0 = periodic, 1 = one-shot (sampled in tick cycles)
//   start        in   one-cycle pulse that arms a one-shot interval
//   period_load  in   captures period_in into the shadow register
//   period_in    in   [WIDTH]      new period value
//   tick         out  one-cycle tick pulse
//   busy         out  high while the FSM is in RUN
//   period_out   out  [WIDTH]      active period value
//   tick_cnt     out  [CNT_WIDTH]  tick counter (only with the macro)
// ---------------------------------------------------------------------------
module ticker_prog #(
  parameter int WIDTH        = 10,
  parameter int RESET_PERIOD = 1000,
  parameter int CNT_WIDTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic             period_load,
  input  logic [WIDTH-1:0] period_in,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] period_out
`ifdef TICKER_PROG_TICK_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] tick_cnt
`endif
);

  // Elaboration-time parameter sanity checks.
  if ((RESET_PERIOD >> WIDTH) != 0 || RESET_PERIOD < 0) begin : g_bad_reset_period
    $error("ticker_prog: RESET_PERIOD does not fit in WIDTH bits");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("ticker_prog: CNT_WIDTH must be at least 1");
  end

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_PERIOD);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] shadow_r;
  logic             pending;

  // The only input in the decode is the enable gate; everything else is
  // registered state, so tick has no path from mode/start/period_in.
  assign tick       = (state == RUN) && enable && (count == period_r);
  assign busy       = (state == RUN);
  assign period_out = period_r;

  // -------------------------------------------------------------------------
  // Next-state / next-count logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_next = state;
    count_next = count;
    if (enable) begin
      unique case (state)
        IDLE: begin
          // Periodic mode starts as soon as it is enabled; one-shot waits
          // for a start pulse. Either way the interval begins at count 0.
          if (!mode || start) begin
            state_next = RUN;
            count_next = '0;
          end
        end
        RUN: begin
          // start is deliberately ignored here; mode only matters at the
          // wrap so a mode change never truncates a running interval.
          if (tick) begin
            count_next = '0;
            if (mode) state_next = IDLE;
          end else begin
            count_next = count + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see pre-edge values regardless of statement order.
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Period staging: shadow register plus pending flag.
  // A load that lands exactly on a tick bypasses the shadow so the new value
  // governs the very next interval. Otherwise the shadow is copied over at
  // the next wrap, or immediately while idle. Transfers are not gated by
  // enable in IDLE since no interval is in progress.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_r <= RESET_VAL;
      shadow_r <= RESET_VAL;
      pending  <= 1'b0;
    end else if (period_load) begin
      shadow_r <= period_in;
      if (tick) begin
        period_r <= period_in;
        pending  <= 1'b0;
      end else begin
        pending  <= 1'b1;
      end
    end else if (pending && (tick || state == IDLE)) begin
      period_r <= shadow_r;
      pending  <= 1'b0;
    end
  end

`ifdef TICKER_PROG_TICK_CNT_EN
  // Tick counter wraps naturally from all-ones to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ticker_prog.sv
// ---------------------------------------------------------------------------
// tb_ticker_prog -- scoreboard bench for ticker_prog (default WIDTH and
// RESET_PERIOD, CNT_WIDTH = 2 so the tick counter wraps quickly).
//
// The driver applies one set of inputs per clock and, from a reference model
// that tracks "cycles remaining until the next tick", pushes the outputs the
// DUT must present in that cycle. An independent monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_ticker_prog;

  localparam int W     = 10;
  localparam int RP    = 1000;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          mode;
  logic          start;
  logic          period_load;
  logic [W-1:0]  period_in;
  logic          tick;
  logic          busy;
  logic [W-1:0]  period_out;
`ifdef TICKER_PROG_TICK_CNT_EN
  logic [CW-1:0] tick_cnt;
`endif

  always #5 clk = ~clk;

  ticker_prog #(
    .WIDTH        (W),
    .RESET_PERIOD (RP),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .start       (start),
    .period_load (period_load),
    .period_in   (period_in),
    .tick        (tick),
    .busy        (busy),
    .period_out  (period_out)
`ifdef TICKER_PROG_TICK_CNT_EN
    ,
    .tick_cnt    (tick_cnt)
`endif
  );

  // ------------------------------------------------------------------------
  // Scoreboard
  // ------------------------------------------------------------------------
  typedef struct {
    logic          tick;
    logic          busy;
    logic [W-1:0]  pout;
    logic [CW-1:0] tcnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ------------------------------------------------------------------------
  // Reference model: an interval is "remaining" enabled cycles long; the
  // tick fires when remaining reaches zero.
  // ------------------------------------------------------------------------
  bit            m_running;
  int            m_remaining;
  int            m_period;
  int            m_shadow;
  bit            m_pending;
  int            m_ticks;

  task automatic model_step(input logic r, en, md, st, pl, input int pin);
    exp_t e;
    bit   t;
    if (r) begin
      m_running   = 0;
      m_remaining = 0;
      m_period    = RP;
      m_shadow    = RP;
      m_pending   = 0;
      m_ticks     = 0;
      e.tick = 1'b0; e.busy = 1'b0; e.pout = W'(RP); e.tcnt = '0;
      exp_q.push_back(e);
      return;
    end
    t = m_running && en && (m_remaining == 0);
    e.tick = t;
    e.busy = m_running;
    e.pout = W'(m_period);
    e.tcnt = CW'(m_ticks % (1 << CW));
    exp_q.push_back(e);

    // Period staging takes effect at this edge.
    if (pl) begin
      m_shadow = pin;
      if (t) begin m_period = pin; m_pending = 0; end
      else   m_pending = 1;
    end else if (m_pending && (t || !m_running)) begin
      m_period  = m_shadow;
      m_pending = 0;
    end

    if (en) begin
      if (!m_running) begin
        if (!md || st) begin
          m_running   = 1;
          m_remaining = m_period;
        end
      end else if (t) begin
        m_ticks++;
        if (md) m_running = 0;
        else    m_remaining = m_period;
      end else begin
        m_remaining--;
      end
    end
  endtask

  // Drive one clock's worth of inputs just after the falling edge.
  task automatic cyc(input logic r, en, md, st, pl, input int pin);
    @(negedge clk);
    reset       = r;
    enable      = en;
    mode        = md;
    start       = st;
    period_load = pl;
    period_in   = W'(pin);
    model_step(r, en, md, st, pl, pin);
  endtask

  task automatic run(input int n, input logic en, md);
    for (int i = 0; i < n; i++) cyc(1'b0, en, md, 1'b0, 1'b0, 0);
  endtask

  // ------------------------------------------------------------------------
  // Monitor: samples mid low phase, after inputs have settled.
  // ------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tick", tick, e.tick);
        check("busy", busy, e.busy);
        check("period_out", period_out, e.pout);
`ifdef TICKER_PROG_TICK_CNT_EN
        check("tick_cnt", tick_cnt, e.tcnt);
`endif
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; start = 1'b0;
    period_load = 1'b0; period_in = '0;

    // Reset state, then periodic run at the default period (two full
    // intervals of 1001 cycles).
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run(1, 1'b0, 1'b0);
    run(2 * 1001 + 500, 1'b1, 1'b0);

    // Load period 3 mid-interval: current interval still ends at 1000,
    // then ticks every 4 cycles. A second load before transfer wins.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    run(520, 1'b1, 1'b0);

    // Load coinciding with a tick governs the next interval: with period 3
    // ticks are 4 apart; sweep the load across four phases.
    for (int ph = 0; ph < 4; ph++) begin
      run(ph, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2 + ph);
      run(12, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
      run(10, 1'b1, 1'b0);
    end

    // Period 0, periodic: tick every enabled cycle; pause for 3 cycles.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    run(10, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    run(6, 1'b1, 1'b0);

    // Back to period 3, pause mid-interval.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    run(6, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    run(8, 1'b1, 1'b0);

    // One-shot: drop into IDLE at next tick, load 5, fire with start, and
    // pulse start again while busy.
    run(8, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5);
    run(3, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run(2, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run(10, 1'b1, 1'b1);
    // Start with enable low is frozen out.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run(3, 1'b1, 1'b1);

    // Reset mid-interval with a load pending: back to IDLE, period 1000.
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run(501, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7);
    run(2, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run(1, 1'b1, 1'b0);
    run(30, 1'b1, 1'b0);

    // Randomized traffic with short periods so ticks are frequent.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 499) == 0,
          $urandom_range(0, 9) != 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 15) == 0,
          int'($urandom_range(0, 7)));
    end

    // Let the monitor drain, then confirm nothing was left unchecked.
    run(1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ticker_prog.md
TICKER_PROG -- requirements
Module: ticker_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 10, counter and period width in bits.
REQ-002 SHALL have parameter RESET_PERIOD, default 1000, period value loaded at reset; SHALL be at most 2^WIDTH-1.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, tick_cnt width (used only with TICKER_PROG_TICK_CNT_EN).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  run gate; low freezes counter and state.
REQ-007 SHALL have port mode  input  1  0 = periodic, 1 = one-shot.
REQ-008 SHALL have port start  input  1  one-cycle pulse that arms a one-shot interval.
REQ-009 SHALL have port period_load  input  1  captures period_in into shadow register.
REQ-010 SHALL have port period_in  input  WIDTH  new period value.
REQ-011 SHALL have port tick  output  1  one-cycle tick pulse.
REQ-012 SHALL have port busy  output  1  high while state is RUN.
REQ-013 SHALL have port period_out  output  WIDTH  active period value.

Function
REQ-014 SHALL contain a WIDTH-bit counter count, an active period period_r, a shadow period shadow_r, a pending flag, and a 2-state FSM IDLE/RUN.
REQ-015 SHALL assert tick only when state = RUN, enable = 1 and count = period_r; tick SHALL be decoded from registers only.
REQ-016 SHALL produce one tick every period_r+1 enabled cycles; period_r = 0 SHALL tick on every enabled RUN cycle.
REQ-017 In RUN with enable = 1, count SHALL increment by 1 each cycle and return to 0 in the cycle after tick; count SHALL never exceed period_r.
REQ-018 With enable = 0, count, state and tick_cnt SHALL hold, and tick SHALL be 0.
REQ-019 IDLE to RUN SHALL occur when mode = 0 and enable = 1, or when mode = 1 and start = 1; count SHALL be 0 on entry.
REQ-020 In RUN with mode = 1 sampled at the tick cycle, the FSM SHALL return to IDLE after that tick and count SHALL clear to 0.
REQ-021 In RUN with mode = 0, the FSM SHALL stay in RUN; mode SHALL be evaluated only in tick cycles.
REQ-022 start SHALL be ignored while in RUN.
REQ-023 period_load SHALL write period_in to shadow_r and set pending on the next edge.
REQ-024 When pending = 1, shadow_r SHALL copy to period_r at the wrap (the tick cycle) or while in IDLE, then pending SHALL clear.
REQ-025 When period_load coincides with a tick, the loaded value SHALL govern the very next interval.
REQ-026 A second period_load before transfer SHALL overwrite shadow_r; last value wins.
REQ-027 period_out SHALL equal period_r.

Reset
REQ-028 reset SHALL asynchronously force count = 0, state = IDLE, period_r = shadow_r = RESET_PERIOD, pending = 0, tick_cnt = 0.
REQ-029 During reset and in the first cycle after release, tick = 0 and busy = 0; reset mid-interval SHALL discard the interval and any pending load.

Configuration
REQ-030 With TICKER_PROG_TICK_CNT_EN defined, the block SHALL add output port tick_cnt (CNT_WIDTH bits, reset 0), which increments by 1 per tick and wraps from 2^CNT_WIDTH-1 to 0.
REQ-031 Without TICKER_PROG_TICK_CNT_EN, tick_cnt and its register SHALL be absent, with all other behaviour identical.

Verification
REQ-032 Reset release, enable = 1, mode = 0, default period -> first tick 1001 cycles after RUN entry, then every 1001 cycles.
REQ-033 Load period 3 mid-interval -> current interval finishes at 1000; subsequent ticks every 4 cycles; period_out = 3 from the wrap.
REQ-034 mode = 1, period 5, start pulse -> busy for 6 cycles, a single tick in the 6th, then IDLE; a start during busy has no effect.
REQ-035 Period 0, periodic -> tick high on every enabled cycle; drop enable for 3 cycles -> tick low, count held, resumes without a lost or extra tick.
REQ-036 Assert reset with count = 500 and a load pending -> count 0, IDLE, period_out = 1000; with the macro defined, tick_cnt = 0 and CNT_WIDTH = 2 wraps 3 to 0 on the 4th tick.
